// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_if
// Purpose  : Bundles every signal between the writeback block and its
//            neighbours (ALU result, load handshake, issue/decode scoreboard
//            query, register-file write port, hold and occupancy status).
// Modports : slave  - used by reg_writeback
//            master - used by the surrounding pipeline (or a bench)
// Revision : 1.0 - initial release
// ============================================================================
interface reg_writeback_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            alu_hold;
  logic [CW-1:0]   fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, rs1_addr, rs2_addr,
    output mem_ready, rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wdata, alu_hold, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  mem_ready, rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wdata, alu_hold, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Purpose  : Writeback arbiter and register scoreboard in front of the
//            register-file write port. ALU results always win; load results
//            are buffered in a small FIFO and drained when the ALU is idle.
//            A starve counter raises alu_hold so a waiting load is not
//            blocked forever. A pending bitmap tells decode which registers
//            still have a write outstanding.
// Ports    : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            bus      - reg_writeback_if.slave (ALU, load handshake, issue,
//                       operand busy query, RF write port, status)
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  reg_writeback_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  // Load FIFO storage (data path only, no reset needed)
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [SW-1:0]   starve;
  logic [SW-1:0]   starve_next;
  logic [31:0]     pending;
  logic [31:0]     pending_next;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            hold_q;

  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            win_valid;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign fifo_empty = (count == '0);
  // Ready depends only on the registered count; a pop in the same cycle
  // does not free a slot for this cycle's offer.
  assign bus.mem_ready = (count < DEPTH_C);
  assign push          = bus.mem_valid && bus.mem_ready;
  assign pop           = !bus.alu_valid && !fifo_empty;
  assign win_valid     = bus.alu_valid || pop;
  assign win_rd        = bus.alu_valid ? bus.alu_rd   : fifo_rd[rd_ptr];
  assign win_data      = bus.alu_valid ? bus.alu_data : fifo_data[rd_ptr];

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.alu_hold   = hold_q;
  assign bus.fifo_count = count;
  assign bus.rs1_busy   = pending[bus.rs1_addr];
  assign bus.rs2_busy   = pending[bus.rs2_addr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // The counter only grows while a load is waiting and the ALU takes the port.
  always_comb begin
    starve_next = starve;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (bus.alu_valid && (starve != LIMIT_C)) begin
      starve_next = starve + 1'b1;
    end
  end

  // Clear from the write leaving the port this cycle, then apply the new
  // issue so a fresh producer of the same register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (rf_we_q) begin
      pending_next[rf_waddr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_next[bus.issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.mem_rd;
      fifo_data[wr_ptr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      pending    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_next;
      starve  <= starve_next;
      pending <= pending_next;
      // Hold follows the counter one cycle later.
      hold_q  <= (starve >= LIMIT_C);
      // A winner to x0 is consumed but never written.
      rf_we_q <= win_valid && (win_rd != 5'd0);
      if (win_valid) begin
        rf_waddr_q <= win_rd;
        rf_wdata_q <= win_data;
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/reg_writeback.md
# reg_writeback

Writeback arbiter and scoreboard sitting in front of the `register_file` write port. It merges single-cycle ALU results and handshaked load results into the one registered write port. It buffers loads in a small FIFO and prevents load starvation. It also keeps a per-register pending bitmap that the decode stage queries before reading operands.

## Interface
- `XLEN`, 32, data width
- `FIFO_DEPTH`, 2, load-result buffer entries (≥2, power of two)
- `STARVE_LIMIT`, 4, consecutive ALU wins over a waiting load before `alu_hold` asserts
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle, no backpressure
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `mem_valid`  in  1  load result offered
- `mem_ready`  out  1  load result accepted when `mem_valid && mem_ready`
- `mem_rd`  in  5  load destination
- `mem_data`  in  XLEN  load result
- `issue_valid`  in  1  instruction with destination issued this cycle
- `issue_rd`  in  5  issued destination
- `rs1_addr`, `rs2_addr`  in  5 each  decode operand addresses
- `rs1_busy`, `rs2_busy`  out  1 each  operand has a pending write
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  5  register-file write address (registered)
- `rf_wdata`  out  XLEN  register-file write data (registered)
- `alu_hold`  out  1  upstream must not present `alu_valid` next cycle
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Load FIFO: push on `mem_valid && mem_ready`. `mem_ready = (fifo_count < FIFO_DEPTH)` comes from registered count only. A same-cycle pop does not raise `mem_ready`. Push and pop in one cycle leave the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Arbitration each cycle: if `alu_valid`, the ALU wins. Otherwise, if the FIFO is non-empty, pop the head. Otherwise no write.
- The winner loads `rf_waddr`/`rf_wdata` at the edge. `rf_we` is 1 only if the winner's rd ≠ 0. An rd = 0 result is consumed (ALU dropped, FIFO popped) with `rf_we` = 0.
- Pending bitmap (32 bits, bit 0 hardwired 0):
  - `issue_valid && issue_rd≠0` sets `pending[issue_rd]`.
  - At each edge where `rf_we` = 1, `pending[rf_waddr]` clears.
  - Set and clear of the same register at the same edge: set wins, because a newer producer exists.
- `rsN_busy = pending[rsN_addr]` (combinational). Always 0 for address 0.
- Starve counter: increments when the FIFO is non-empty and the ALU wins. Clears on any FIFO pop or when the FIFO is empty. Saturates at `STARVE_LIMIT`.
- `alu_hold`: registered, equals (counter ≥ `STARVE_LIMIT`). While `alu_hold` = 1 the next cycle guarantees a FIFO pop. `alu_valid` during `alu_hold` is a protocol violation: the ALU still wins, and a bench assertion fires.
- Reset (asynchronous, any time including mid-transfer):
  - FIFO emptied, pending = 0, counter = 0.
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0.
  - `alu_hold` = 0, `mem_ready` = 1, `fifo_count` = 0.
  - In-flight results are lost.

## Timing
- ALU path: `alu_valid` sampled at edge N. `rf_we` high in cycle N..N+1. Register file written and pending cleared at edge N+1.
- Load path, FIFO empty, no ALU: accepted at edge N. Popped at edge N+1. Written at edge N+2.
- Full FIFO: `mem_ready` drops the cycle after the filling edge. It rises the cycle after the first pop edge.
- `alu_hold` rises one cycle after the counter reaches the limit. It falls one cycle after the forced pop.
- `rsN_busy` reflects `issue_valid` from edge N onward. It deasserts in the cycle after the register file captures the data, so a decoder read never sees stale data.

## Test plan
- Reset, then ALU writes x5 = 0xDEADBEEF with `issue_rd`=5 one cycle earlier → `rs1_busy`(x5) = 1 until `rf_we`/`rf_waddr`=5/0xDEADBEEF is consumed, then 0.
- Load x7 = 0x12345678 alone → `rf_we` two edges after acceptance, `fifo_count` goes 0→1→0.
- Two loads back-to-back while the ALU is continuously valid → FIFO fills, `mem_ready`=0 the next cycle, and `alu_hold`=1 after `STARVE_LIMIT`=4 ALU wins. The upstream drops `alu_valid`, the head is written, and `alu_hold` clears.
- ALU result to x0 with data 0xFFFFFFFF → `rf_we` stays 0. Issue to x0 → `rs*_busy` stays 0.
- Same-edge `issue_rd`=9 and `rf_we` writing x9 → `pending[9]` remains 1.
- `reset_n` pulled low asynchronously with 2 FIFO entries and pending bits set → outputs take reset values immediately. After release, `mem_ready`=1, `fifo_count`=0, and no stale write appears.
